// File: rtl/bus_burst_sram_responder_if.sv
// Shared burst bus bundle between the DMA initiator (master) and a memory responder (slave).
// Latency: none, wires only.
// Backpressure: busy_out from the responder stalls write beats; reads cannot be stalled.
interface bus_burst_sram_responder_if;
    logic        begin_transaction_in;
    logic [31:0] address_data_in;
    logic [3:0]  byte_enables_in;
    logic [7:0]  burst_size_in;
    logic        read_n_write_in;
    logic        data_valid_in;
    logic        end_transaction_in;
    logic [31:0] address_data_out;
    logic        data_valid_out;
    logic        end_transaction_out;
    logic        busy_out;
    logic        error_out;

    modport slave (
        input  begin_transaction_in, address_data_in, byte_enables_in, burst_size_in,
        input  read_n_write_in, data_valid_in, end_transaction_in,
        output address_data_out, data_valid_out, end_transaction_out, busy_out, error_out
    );

    modport master (
        output begin_transaction_in, address_data_in, byte_enables_in, burst_size_in,
        output read_n_write_in, data_valid_in, end_transaction_in,
        input  address_data_out, data_valid_out, end_transaction_out, busy_out, error_out
    );
endinterface

// File: rtl/bus_burst_sram_responder.sv
// Burst bus responder backed by a local 32-bit word SRAM; outputs are 0 when idle so they can be OR-ed onto the bus.
// Latency: first read beat 2 cycles after begin, then 1 beat/cycle (1 per 2 cycles with waits); writes land on the beat cycle.
// Backpressure: reads cannot be stalled; BURST_RESPONDER_WAIT_STATES_EN adds a wait after each beat and raises busy_out on writes.
module bus_burst_sram_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_WIDTH   = 9
) (
    input  logic                        clock,
    input  logic                        reset,
    bus_burst_sram_responder_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_BURST,
        RD_END,
        WR_BURST,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            cnt_q, cnt_d;      // beats still to be read or written
    logic [3:0]            be_q, be_d;
    logic                  dv_q, dv_d;
    logic                  end_q, end_d;
    logic                  err_q, err_d;
`ifdef BURST_RESPONDER_WAIT_STATES_EN
    logic                  wait_q, wait_d;    // read side: current beat is followed by a gap
    logic                  busy_q, busy_d;
`endif

    logic                  sel;
    logic                  accept;
    logic                  mem_re;
    logic                  mem_we;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_data_q;

    assign sel = bus.begin_transaction_in &&
                 (bus.address_data_in[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);

`ifdef BURST_RESPONDER_WAIT_STATES_EN
    assign accept       = bus.data_valid_in && !busy_q;
    assign bus.busy_out = busy_q;
`else
    assign accept       = bus.data_valid_in;
    assign bus.busy_out = 1'b0;
`endif

    // Read data is only driven while a beat is presented, keeping the bus OR-able.
    assign bus.address_data_out    = dv_q ? rd_data_q : 32'h0;
    assign bus.data_valid_out      = dv_q;
    assign bus.end_transaction_out = end_q;
    assign bus.error_out           = err_q;

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        be_d    = be_q;
        dv_d    = 1'b0;
        end_d   = 1'b0;
        err_d   = 1'b0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
`ifdef BURST_RESPONDER_WAIT_STATES_EN
        wait_d  = wait_q;
        busy_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sel) begin
                    addr_d = bus.address_data_in[ADDR_WIDTH+1:2];
                    cnt_d  = {1'b0, bus.burst_size_in} + 9'd1;
                    be_d   = bus.byte_enables_in;
`ifdef BURST_RESPONDER_WAIT_STATES_EN
                    wait_d = 1'b0;
`endif
                    if (bus.address_data_in[1:0] != 2'b00) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        end_d   = 1'b1;
                    end else if (bus.read_n_write_in) begin
                        state_d = RD_FETCH;
                    end else begin
                        state_d = WR_BURST;
                    end
                end
            end
            RD_FETCH: begin
                mem_re  = 1'b1;
                addr_d  = addr_q + ADDR_ONE;
                cnt_d   = cnt_q - 9'd1;
                dv_d    = 1'b1;
                state_d = RD_BURST;
            end
            RD_BURST: begin
                if (cnt_q == 9'd0) begin
                    end_d   = 1'b1;
                    state_d = RD_END;
`ifdef BURST_RESPONDER_WAIT_STATES_EN
                end else if (!wait_q) begin
                    wait_d = 1'b1;
`endif
                end else begin
                    mem_re = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q - 9'd1;
                    dv_d   = 1'b1;
`ifdef BURST_RESPONDER_WAIT_STATES_EN
                    wait_d = 1'b0;
`endif
                end
            end
            RD_END: begin
                state_d = IDLE;
            end
            WR_BURST: begin
                // Beats past the latched count are accepted but silently dropped.
                if (accept && cnt_q != 9'd0) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q - 9'd1;
                end
`ifdef BURST_RESPONDER_WAIT_STATES_EN
                busy_d = accept && !bus.end_transaction_in;
`endif
                if (bus.end_transaction_in) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, counters and registered bus outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
            dv_q    <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef BURST_RESPONDER_WAIT_STATES_EN
            wait_q  <= 1'b0;
            busy_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            be_q    <= be_d;
            dv_q    <= dv_d;
            end_q   <= end_d;
            err_q   <= err_d;
`ifdef BURST_RESPONDER_WAIT_STATES_EN
            wait_q  <= wait_d;
            busy_q  <= busy_d;
`endif
        end
    end

    // Word SRAM: byte-lane writes and a synchronous read port; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= bus.address_data_in[8*i +: 8];
                end
            end
        end
        if (mem_re) begin
            rd_data_q <= mem[addr_q];
        end
    end
endmodule

// File: tb/tb_bus_burst_sram_responder.sv
// Directed plus randomized bench for bus_burst_sram_responder with a word-array memory model.
// Latency: expected beats placed at fixed cycle offsets from the begin cycle.
// Backpressure: write driver holds a beat while busy_out is high.
module tb_bus_burst_sram_responder;
`ifdef BURST_RESPONDER_WAIT_STATES_EN
    localparam int S    = 2;
    localparam bit WAIT = 1'b1;
`else
    localparam int S    = 1;
    localparam bit WAIT = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h5000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bus_burst_sram_responder_if bus_if ();

    bus_burst_sram_responder #(
        .BASE_ADDRESS (BASE),
        .ADDR_WIDTH   (9)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [512];
    logic [31:0] rd_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus_if.begin_transaction_in = 1'b0;
        bus_if.address_data_in      = 32'h0;
        bus_if.byte_enables_in      = 4'h0;
        bus_if.burst_size_in        = 8'h0;
        bus_if.read_n_write_in      = 1'b0;
        bus_if.data_valid_in        = 1'b0;
        bus_if.end_transaction_in   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {28'h0, bus_if.data_valid_out, bus_if.end_transaction_out,
                              bus_if.busy_out, bus_if.error_out}, 32'h0);
        check({tag, "_dat"}, bus_if.address_data_out, 32'h0);
    endtask

    task automatic start(input logic [10:0] off, input int bs, input logic [3:0] be, input bit rnw);
        bus_if.begin_transaction_in = 1'b1;
        bus_if.address_data_in      = {BASE[31:11], off};
        bus_if.byte_enables_in      = be;
        bus_if.burst_size_in        = 8'(bs);
        bus_if.read_n_write_in      = rnw;
        bus_if.data_valid_in        = 1'b0;
        bus_if.end_transaction_in   = 1'b0;
    endtask

    // Offers nbeats beats (data base+i or random), optional bubbles; last offered beat carries end.
    task automatic wr_burst(input logic [10:0] off, input int bs, input logic [3:0] be, input int nbeats,
                            input bit bubbles, input bit rnd, input logic [31:0] base);
        logic [31:0] d;
        int          sent;
        int          acc;
        int          guard;
        int          idx;
        bit          prev_acc;
        start(off, bs, be, 1'b0);
        @(negedge clock);
        drive_idle();
        sent = 0; acc = 0; guard = 0; prev_acc = 1'b0;
        d = rnd ? $urandom : base;
        while (sent < nbeats && guard < 4000) begin
            guard++;
            check("wr_busy", {31'h0, bus_if.busy_out}, {31'h0, WAIT && prev_acc});
            check("wr_quiet", {29'h0, bus_if.data_valid_out, bus_if.end_transaction_out, bus_if.error_out}, 32'h0);
            if (bubbles && $urandom_range(0, 3) == 0) begin
                bus_if.data_valid_in      = 1'b0;
                bus_if.end_transaction_in = 1'b0;
                prev_acc = 1'b0;
            end else begin
                bus_if.data_valid_in   = 1'b1;
                bus_if.address_data_in = d;
                if (bus_if.busy_out) begin
                    bus_if.end_transaction_in = 1'b0;
                    prev_acc = 1'b0;
                end else begin
                    bus_if.end_transaction_in = (sent == nbeats - 1);
                    prev_acc = 1'b1;
                    if (acc <= bs) begin
                        idx = (int'(off[10:2]) + acc) % 512;
                        for (int i = 0; i < 4; i++)
                            if (be[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
                    end
                    acc++;
                    sent++;
                    d = rnd ? $urandom : base + 32'(sent);
                end
            end
            @(negedge clock);
        end
        check("wr_done", 32'(sent), 32'(nbeats));
        drive_idle();
    endtask

    // Reads bs+1 beats and checks every cycle against beat positions derived from the stride.
    task automatic rd_burst(input logic [10:0] off, input int bs, input bit inject);
        int          n;
        int          last_off;
        int          end_off;
        bit          exp_dv;
        logic [31:0] exp_d;
        n        = bs + 1;
        last_off = 2 + (n - 1) * S;
        end_off  = last_off + 1;
        start(off, bs, 4'h0, 1'b1);
        @(negedge clock);
        for (int c = 1; c <= end_off + 1; c++) begin
            exp_dv = (c >= 2) && (c <= last_off) && (((c - 2) % S) == 0);
            exp_d  = 32'h0;
            if (exp_dv) exp_d = mdl[(int'(off[10:2]) + (c - 2) / S) % 512];
            check("rd_dv",  {31'h0, bus_if.data_valid_out}, {31'h0, exp_dv});
            check("rd_dat", bus_if.address_data_out, exp_d);
            check("rd_end", {31'h0, bus_if.end_transaction_out}, {31'h0, c == end_off});
            check("rd_err", {31'h0, bus_if.error_out}, 32'h0);
            if (exp_dv && c == 2) rd_first = bus_if.address_data_out;
            if (c == 1 && inject) begin
                start(off ^ 11'h100, 0, 4'hF, 1'b1);
            end else begin
                drive_idle();
            end
            @(negedge clock);
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // 1: idle after reset, then an out-of-window begin
        for (int i = 0; i < 10; i++) begin
            check_quiet("reset_idle");
            @(negedge clock);
        end
        bus_if.begin_transaction_in = 1'b1;
        bus_if.address_data_in      = 32'h6000_0000;
        bus_if.read_n_write_in      = 1'b1;
        @(negedge clock);
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            check_quiet("unselected");
            @(negedge clock);
        end

        // Fill the whole SRAM so every model word is known
        wr_burst(11'h000, 255, 4'hF, 256, 1'b0, 1'b1, 32'h0);
        wr_burst(11'h400, 255, 4'hF, 256, 1'b0, 1'b1, 32'h0);

        // 2: single write then single read
        wr_burst(11'h040, 0, 4'hF, 1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        rd_burst(11'h040, 0, 1'b0);
        check("t2_single", rd_first, 32'hDEAD_BEEF);

        // 3: 8-beat write and read back
        wr_burst(11'h05C, 7, 4'hF, 8, 1'b0, 1'b0, 32'h10);
        rd_burst(11'h05C, 7, 1'b0);
        check("t3_first", rd_first, 32'h10);

        // 4: partial byte enables
        wr_burst(11'h080, 0, 4'hF, 1, 1'b0, 1'b0, 32'h1122_3344);
        wr_burst(11'h080, 0, 4'b0101, 1, 1'b0, 1'b0, 32'hAABB_CCDD);
        rd_burst(11'h080, 0, 1'b0);
        check("t4_bytes", rd_first, 32'h11BB_33DD);

        // 5: wrapping read, misaligned read and write begins
        rd_burst(11'h7F8, 3, 1'b0);
        start(11'h042, 0, 4'hF, 1'b1);
        @(negedge clock);
        drive_idle();
        check("err_pulse", {30'h0, bus_if.error_out, bus_if.end_transaction_out}, 32'h3);
        check("err_dv", {31'h0, bus_if.data_valid_out}, 32'h0);
        @(negedge clock);
        check_quiet("err_after");
        start(11'h042, 0, 4'hF, 1'b0);
        @(negedge clock);
        bus_if.begin_transaction_in = 1'b0;
        bus_if.data_valid_in        = 1'b1;
        bus_if.address_data_in      = 32'h0BAD_0BAD;
        bus_if.end_transaction_in   = 1'b1;
        @(negedge clock);
        drive_idle();
        @(negedge clock);
        rd_burst(11'h040, 0, 1'b0);
        check("err_nowrite", rd_first, 32'hDEAD_BEEF);

        // Over-long write: extra beats dropped, bubbles ignored
        wr_burst(11'h100, 1, 4'hF, 4, 1'b1, 1'b1, 32'h0);
        rd_burst(11'h100, 3, 1'b0);

        // 6: reset during the third beat of an 8-beat read
        start(11'h200, 7, 4'h0, 1'b1);
        @(negedge clock);
        drive_idle();
        repeat (1 + 2 * S) @(negedge clock);
        check("rst_beat3_dv", {31'h0, bus_if.data_valid_out}, 32'h1);
        check("rst_beat3_dat", bus_if.address_data_out, mdl[130]);
        reset = 1'b1;
        @(negedge clock);
        check_quiet("rst_mid");
        reset = 1'b0;
        @(negedge clock);
        check_quiet("rst_release");
        rd_burst(11'h200, 7, 1'b0);

        // Randomized mix of reads and writes
        for (int it = 0; it < 30; it++) begin
            logic [10:0] off;
            int          bs;
            off = {9'($urandom_range(0, 511)), 2'b00};
            bs  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0)
                wr_burst(off, bs, 4'($urandom_range(1, 15)), bs + 1 + $urandom_range(0, 2),
                         1'b1, 1'b1, 32'h0);
            else
                rd_burst(off, bs, 1'($urandom_range(0, 1)));
        end

        // Sweep the whole memory against the model
        rd_burst(11'h000, 255, 1'b0);
        rd_burst(11'h400, 255, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
